pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 30, width of the word-addressed PC (byte address bits [ADDR_W+1:2]).
REQ-002 Parameter START_ADDR, default 30'h0000BFF, PC value on reset.
REQ-003 Parameter EXC_VEC, default 30'h0000C00, exception entry word address.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >=2.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 PCWrite  input  1  advance enable; 0 = stall.
REQ-008 exc_req  input  1  exception redirect request.
REQ-009 br_taken / br_target  input  1 / ADDR_W  resolved-branch redirect.
REQ-010 jmp / jmp_target  input  1 / ADDR_W  unconditional jump.
REQ-011 call  input  1  qualifies jmp as a call (push return address).
REQ-012 ret  input  1  return; target = RAS top.
REQ-013 PC  output  ADDR_W  current fetch word address (registered).
REQ-014 pc_valid  output  1  PC is a valid fetch address this cycle.
REQ-015 ras_empty / ras_full  output  1 / 1  stack occupancy flags.
REQ-016 ras_ovf  output  1  sticky: a push discarded an entry.
REQ-017 ret_miss  output  1  one-cycle pulse: ret taken with RAS empty.

Function
REQ-018 FSM states BOOT, RUN, EXC_FLUSH; all outputs registered.
REQ-019 BOOT: PC=START_ADDR, pc_valid=0; next cycle -> RUN unconditionally (one-cycle boot bubble).
REQ-020 RUN, exc_req=1: PC<=EXC_VEC, -> EXC_FLUSH, regardless of PCWrite; RAS unchanged.
REQ-021 EXC_FLUSH: pc_valid=0, PC held, RAS unchanged, inputs ignored; next cycle -> RUN.
REQ-022 RUN, exc_req=0, PCWrite=0: PC, RAS, flags hold; all redirect inputs ignored (no queuing).
REQ-023 RUN, exc_req=0, PCWrite=1, next-PC priority: br_taken -> br_target; else ret -> RAS top (pop); else jmp -> jmp_target; else PC+1.
REQ-024 PC+1 wraps modulo 2^ADDR_W (all-ones -> 0), no flag.
REQ-025 Push occurs only when jmp&call is the selected source; pushed value = PC+1 (mod 2^ADDR_W).
REQ-026 call without jmp is ignored; call with a higher-priority source selected causes no push.
REQ-027 Push when full: oldest entry discarded (circular), count stays RAS_DEPTH, ras_ovf<=1.
REQ-028 ret selected with RAS empty: next PC = PC+1, no pop, ret_miss=1 for that cycle.
REQ-029 Pop and push never occur in the same cycle (priority guarantees it).
REQ-030 ras_empty = (count==0), ras_full = (count==RAS_DEPTH), updated same edge as count.
REQ-031 pc_valid=1 in RUN; PC updates on the edge the selecting inputs are sampled (one-cycle redirect latency).

Reset
REQ-032 reset=0 asynchronously forces: state BOOT, PC=START_ADDR, pc_valid=0, RAS count 0, ras_empty=1, ras_full=0, ras_ovf=0, ret_miss=0.
REQ-033 Reset asserted mid-redirect or mid-EXC_FLUSH discards the operation; no partial RAS update.
REQ-034 First posedge after reset deassertion executes BOOT; first valid PC (START_ADDR) visible with pc_valid=1 one cycle later.
REQ-035 ras_ovf clears only on reset.

Verification
REQ-036 Release reset, PCWrite=1, no requests -> PC 0xBFF (valid=0), 0xBFF (valid=1), 0xC00, 0xC01.
REQ-037 At PC=0x100: jmp=1,call=1,jmp_target=0x200 -> PC 0x200, RAS top 0x101; then ret=1 -> PC 0x101, ras_empty=1.
REQ-038 Same cycle br_taken=1 (0x300), ret=1, jmp=1, call=1 -> PC 0x300, RAS count unchanged, no ret_miss.
REQ-039 Five calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1; four rets return the last four return addresses in LIFO order; fifth ret -> ret_miss pulse, PC+1.
REQ-040 PCWrite=0 with exc_req=1 at PC=0x150 -> PC 0xC00, one pc_valid=0 cycle, then RUN; PCWrite=0 alone holds PC for N cycles.
REQ-041 ADDR_W=8, PC=0xFF, no requests -> PC 0x00; reset pulse during EXC_FLUSH -> PC=START_ADDR, RAS empty.

Source files
------------

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : Fetch PC generator with boot/exception bubbles and a circular
//               return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen #(
    parameter int                ADDR_W     = 30,
    parameter logic [ADDR_W-1:0] START_ADDR = 30'h0000BFF,
    parameter logic [ADDR_W-1:0] EXC_VEC    = 30'h0000C00,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWrite,
    input  logic              exc_req,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] PC,
    output logic              pc_valid,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ret_miss
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_BOOT      = 2'd0,
        S_RUN       = 2'd1,
        S_EXC_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              r_valid;
    logic              r_empty;
    logic              r_full;
    logic              r_ovf;
    logic              r_miss;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_sp;
    logic [PTR_W-1:0]  w_sp_nxt;
    logic [PTR_W-1:0]  w_top_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_cnt_full;
    logic              w_push;
    logic              w_pop;
    logic              w_miss;

    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_top_idx  = r_sp - PTR_W'(1);
    assign w_cnt_full = (r_cnt == CNT_W'(RAS_DEPTH));

    // Next-PC selection: exception, then branch > return > jump > sequential.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            S_BOOT:      w_state_nxt = S_RUN;
            S_EXC_FLUSH: w_state_nxt = S_RUN;
            S_RUN: begin
                if (exc_req) begin
                    w_state_nxt = S_EXC_FLUSH;
                    w_pc_nxt    = EXC_VEC;
                end else if (PCWrite) begin
                    if (br_taken) begin
                        w_pc_nxt = br_target;
                    end else if (ret) begin
                        if (r_cnt != '0) begin
                            w_pop    = 1'b1;
                            w_pc_nxt = r_ras[w_top_idx];
                        end else begin
                            w_miss   = 1'b1;
                            w_pc_nxt = w_pc_inc;
                        end
                    end else if (jmp) begin
                        w_push   = call;
                        w_pc_nxt = jmp_target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            default:     w_state_nxt = S_BOOT;
        endcase
    end

    // A push onto a full stack overwrites the oldest slot, so count saturates.
    always_comb begin
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_cnt;
        if (w_push) begin
            w_sp_nxt = r_sp + PTR_W'(1);
            if (!w_cnt_full) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (w_pop) begin
            w_sp_nxt  = w_top_idx;
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
            r_pc    <= START_ADDR;
            r_valid <= 1'b0;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= (w_state_nxt == S_RUN);
            r_sp    <= w_sp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CNT_W'(RAS_DEPTH));
            r_ovf   <= r_ovf | (w_push & w_cnt_full);
            r_miss  <= w_miss;
        end
    end

    // Storage needs no reset: entries are only readable once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_sp] <= w_pc_inc;
        end
    end

    assign PC        = r_pc;
    assign pc_valid  = r_valid;
    assign ras_empty = r_empty;
    assign ras_full  = r_full;
    assign ras_ovf   = r_ovf;
    assign ret_miss  = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen (30-bit and 8-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          reset;
    logic          b_reset;
    logic          PCWrite, exc_req, br_taken, jmp, call, ret;
    logic [AW-1:0] br_target, jmp_target;
    logic [AW-1:0] PC;
    logic          pc_valid, ras_empty, ras_full, ras_ovf, ret_miss;
    logic [7:0]    b_pc;
    logic          b_valid, b_empty, b_full, b_ovf, b_miss;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W(30), .START_ADDR(30'h0000BFF), .EXC_VEC(30'h0000C00), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .exc_req(exc_req),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp),
        .jmp_target(jmp_target), .call(call), .ret(ret), .PC(PC),
        .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ret_miss(ret_miss)
    );

    pc_gen #(
        .ADDR_W(8), .START_ADDR(8'h10), .EXC_VEC(8'h80), .RAS_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(b_reset), .PCWrite(PCWrite), .exc_req(exc_req),
        .br_taken(br_taken), .br_target(br_target[7:0]), .jmp(jmp),
        .jmp_target(jmp_target[7:0]), .call(call), .ret(ret), .PC(b_pc),
        .pc_valid(b_valid), .ras_empty(b_empty), .ras_full(b_full),
        .ras_ovf(b_ovf), .ret_miss(b_miss)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PCWrite = 1'b1; exc_req = 1'b0; br_taken = 1'b0; jmp = 1'b0;
        call = 1'b0; ret = 1'b0; br_target = '0; jmp_target = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0; b_reset = 1'b0;
        cyc();
        reset = 1'b1;
        repeat (4) cyc();
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({PC, pc_valid, ras_empty, ras_full, ras_ovf, ret_miss} !== {30'h0000BFF, 5'b01000})
            $display("FAIL reset_async got=%h/%b%b%b%b%b exp=bff/01000",
                     PC, pc_valid, ras_empty, ras_full, ras_ovf, ret_miss);
        else n_pass++;
        cyc();
    endtask

    task automatic test_boot();
        logic [AW-1:0] exp_pc [4];
        logic          exp_v  [4];
        exp_pc = '{30'h0000BFF, 30'h0000BFF, 30'h0000C00, 30'h0000C01};
        exp_v  = '{1'b0, 1'b1, 1'b1, 1'b1};
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) cyc();
            n_total++;
            if ({PC, pc_valid} !== {exp_pc[i], exp_v[i]})
                $display("FAIL boot_seq%0d got=%h/%b exp=%h/%b", i, PC, pc_valid, exp_pc[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_call_ret();
        jmp = 1'b1; jmp_target = 30'h100;
        cyc(); idle();
        n_total++;
        if (PC !== 30'h100) $display("FAIL jmp_plain got=%h exp=100", PC);
        else n_pass++;
        jmp = 1'b1; call = 1'b1; jmp_target = 30'h200;
        cyc(); idle();
        n_total++;
        if ({PC, ras_empty} !== {30'h200, 1'b0})
            $display("FAIL call got=%h/%b exp=200/0", PC, ras_empty);
        else n_pass++;
        ret = 1'b1;
        cyc(); idle();
        n_total++;
        if ({PC, ras_empty} !== {30'h101, 1'b1})
            $display("FAIL ret got=%h/%b exp=101/1", PC, ras_empty);
        else n_pass++;
    endtask

    task automatic test_priority();
        jmp = 1'b1; call = 1'b1; jmp_target = 30'h250;
        cyc(); idle();
        br_taken = 1'b1; br_target = 30'h300; ret = 1'b1;
        jmp = 1'b1; call = 1'b1; jmp_target = 30'h400;
        cyc(); idle();
        n_total++;
        if ({PC, ras_empty, ras_full, ret_miss} !== {30'h300, 3'b000})
            $display("FAIL prio_branch got=%h/%b%b%b exp=300/000", PC, ras_empty, ras_full, ret_miss);
        else n_pass++;
        ret = 1'b1;
        cyc(); idle();
        n_total++;
        if ({PC, ras_empty} !== {30'h102, 1'b1})
            $display("FAIL prio_ras_intact got=%h/%b exp=102/1", PC, ras_empty);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [AW-1:0] ra [5];
        logic [AW-1:0] cur;
        cur = PC;
        for (int i = 0; i < 5; i++) begin
            ra[i] = cur + 30'd1;
            jmp = 1'b1; call = 1'b1; jmp_target = 30'h400 + AW'(i * 16);
            cyc(); idle();
            cur = 30'h400 + AW'(i * 16);
        end
        n_total++;
        if ({PC, ras_full, ras_ovf} !== {30'h440, 2'b11})
            $display("FAIL ovf_flags got=%h/%b%b exp=440/11", PC, ras_full, ras_ovf);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            ret = 1'b1;
            cyc(); idle();
            n_total++;
            if (PC !== ra[4-k]) $display("FAIL ovf_ret%0d got=%h exp=%h", k, PC, ra[4-k]);
            else n_pass++;
            cur = ra[4-k];
        end
        ret = 1'b1;
        cyc(); idle();
        n_total++;
        if ({PC, ret_miss, ras_empty, ras_ovf} !== {cur + 30'd1, 3'b111})
            $display("FAIL ret_miss got=%h/%b%b%b exp=%h/111", PC, ret_miss, ras_empty, ras_ovf, cur + 30'd1);
        else n_pass++;
        cyc();
        n_total++;
        if ({PC, ret_miss} !== {cur + 30'd2, 1'b0})
            $display("FAIL ret_miss_pulse got=%h/%b exp=%h/0", PC, ret_miss, cur + 30'd2);
        else n_pass++;
    endtask

    task automatic test_exc_stall();
        jmp = 1'b1; jmp_target = 30'h150;
        cyc(); idle();
        PCWrite = 1'b0; exc_req = 1'b1;
        cyc(); idle();
        n_total++;
        if ({PC, pc_valid} !== {30'h0000C00, 1'b0})
            $display("FAIL exc_entry got=%h/%b exp=c00/0", PC, pc_valid);
        else n_pass++;
        br_taken = 1'b1; br_target = 30'h555;
        cyc(); idle();
        n_total++;
        if ({PC, pc_valid} !== {30'h0000C00, 1'b1})
            $display("FAIL exc_flush got=%h/%b exp=c00/1", PC, pc_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            PCWrite = 1'b0; br_taken = 1'b1; br_target = 30'h777; ret = 1'b1; jmp = 1'b1;
            cyc();
            n_total++;
            if ({PC, pc_valid} !== {30'h0000C00, 1'b1})
                $display("FAIL stall%0d got=%h/%b exp=c00/1", i, PC, pc_valid);
            else n_pass++;
        end
        idle();
        cyc();
        n_total++;
        if (PC !== 30'h0000C01) $display("FAIL stall_release got=%h exp=c01", PC);
        else n_pass++;
    endtask

    task automatic test_wrap();
        idle();
        b_reset = 1'b1;
        cyc();
        n_total++;
        if ({b_pc, b_valid} !== {8'h10, 1'b1}) $display("FAIL w_boot got=%h/%b exp=10/1", b_pc, b_valid);
        else n_pass++;
        jmp = 1'b1; call = 1'b1; jmp_target = 30'hFF;
        cyc(); idle();
        n_total++;
        if ({b_pc, b_empty} !== {8'hFF, 1'b0}) $display("FAIL w_call got=%h/%b exp=ff/0", b_pc, b_empty);
        else n_pass++;
        cyc();
        n_total++;
        if (b_pc !== 8'h00) $display("FAIL w_wrap got=%h exp=00", b_pc);
        else n_pass++;
        exc_req = 1'b1;
        cyc(); idle();
        n_total++;
        if ({b_pc, b_valid} !== {8'h80, 1'b0}) $display("FAIL w_exc got=%h/%b exp=80/0", b_pc, b_valid);
        else n_pass++;
        #2 b_reset = 1'b0;
        #1;
        n_total++;
        if ({b_pc, b_valid, b_empty, b_full, b_ovf} !== {8'h10, 4'b0100})
            $display("FAIL w_reset_flush got=%h/%b%b%b%b exp=10/0100", b_pc, b_valid, b_empty, b_full, b_ovf);
        else n_pass++;
        cyc();
        b_reset = 1'b1;
        cyc();
        ret = 1'b1;
        cyc(); idle();
        n_total++;
        if ({b_pc, b_miss, b_empty} !== {8'h11, 2'b11})
            $display("FAIL w_ras_cleared got=%h/%b%b exp=11/11", b_pc, b_miss, b_empty);
        else n_pass++;
        b_reset = 1'b0;
    endtask

    task automatic test_random();
        logic [AW-1:0] m_pc;
        logic          m_valid, m_ovf, m_miss;
        logic [AW-1:0] m_q [$];
        idle();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        m_pc = 30'h0000BFF; m_valid = 1'b0; m_ovf = 1'b0; m_miss = 1'b0;
        m_q.delete();
        for (int n = 0; n < 400; n++) begin
            exc_req    = ($urandom_range(0, 19) == 0);
            PCWrite    = ($urandom_range(0, 3) != 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            ret        = ($urandom_range(0, 3) == 0);
            jmp        = ($urandom_range(0, 1) == 0);
            call       = ($urandom_range(0, 2) != 0);
            br_target  = AW'($urandom);
            jmp_target = AW'($urandom);
            cyc();
            m_miss = 1'b0;
            if (!m_valid) begin
                m_valid = 1'b1;
            end else if (exc_req) begin
                m_pc = 30'h0000C00; m_valid = 1'b0;
            end else if (PCWrite) begin
                if (br_taken) m_pc = br_target;
                else if (ret) begin
                    if (m_q.size() > 0) m_pc = m_q.pop_back();
                    else begin m_pc = m_pc + 30'd1; m_miss = 1'b1; end
                end else if (jmp) begin
                    if (call) begin
                        m_q.push_back(m_pc + 30'd1);
                        if (m_q.size() > 4) begin void'(m_q.pop_front()); m_ovf = 1'b1; end
                    end
                    m_pc = jmp_target;
                end else m_pc = m_pc + 30'd1;
            end
            n_total++;
            if ({PC, pc_valid, ras_empty, ras_full, ras_ovf, ret_miss} !==
                {m_pc, m_valid, m_q.size() == 0, m_q.size() == 4, m_ovf, m_miss})
                $display("FAIL rand%0d got=%h/%b%b%b%b%b exp=%h/%b%b%b%b%b", n,
                         PC, pc_valid, ras_empty, ras_full, ras_ovf, ret_miss,
                         m_pc, m_valid, m_q.size() == 0, m_q.size() == 4, m_ovf, m_miss);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_call_ret();
        test_priority();
        test_overflow();
        test_exc_stall();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
